// File: rtl/io_pkg.sv
// Shared definitions for the io_responder peripheral:
// register map, FSM state encoding and STATUS bit positions.
package io_pkg;

    localparam logic [3:0] ADDR_OUT0   = 4'd0;
    localparam logic [3:0] ADDR_OUT1   = 4'd1;
    localparam logic [3:0] ADDR_IN0    = 4'd2;
    localparam logic [3:0] ADDR_IN1    = 4'd3;
    localparam logic [3:0] ADDR_TIMER  = 4'd4;
    localparam logic [3:0] ADDR_TCMP   = 4'd5;
    localparam logic [3:0] ADDR_STATUS = 4'd6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_ACK  = 2'd2;
    localparam state_t ST_HOLD = 2'd3;

    localparam int STATUS_FLAG_BIT = 0;
    localparam int STATUS_IE_BIT   = 1;

endpackage

// File: rtl/io_timer.sv
// Prescaled up-counter with a compare register; a compare match on a tick
// restarts the count and raises a sticky flag.
module io_timer #(
    parameter int WIDTH = 8,
    parameter int PRESC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_count,
    input  logic [WIDTH-1:0] tcmp,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] count,
    output logic             flag
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic          match;

    assign tick  = (presc == PRESC_LAST);
    assign match = tick && (tcmp != '0) && (count == tcmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (clr_count || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr_count || match) begin
            count <= '0;
        end else if (tick) begin
            count <= count + WIDTH'(1);
        end
    end

    // A TIMER write suppresses the match of the same tick; a new match beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag <= 1'b0;
        end else if (match && !clr_count) begin
            flag <= 1'b1;
        end else if (clr_flag) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped peripheral on the CPU load/store bus: two output ports, two
// synchronised input ports and a compare timer behind a req/ack handshake.
module io_responder #(
    parameter int WIDTH       = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int PRESC       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ack,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             irq
);

    import io_pkg::*;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t           state;
    state_t           next_state;
    logic [3:0]       wait_cnt;
    logic             req_we;
    logic [3:0]       req_addr;
    logic [WIDTH-1:0] req_wdata;

    logic [WIDTH-1:0] in0_meta;
    logic [WIDTH-1:0] in0_sync;
    logic [WIDTH-1:0] in1_meta;
    logic [WIDTH-1:0] in1_sync;

    logic [WIDTH-1:0] tcmp;
    logic             ie;
    logic [WIDTH-1:0] count;
    logic             flag;
    logic             wr_en;
    logic             clr_count;
    logic             clr_flag;
    logic [WIDTH-1:0] read_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    next_state = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (!req) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ack   = 1'b0;
        rdata = '0;
        if (state == ST_ACK) begin
            ack   = 1'b1;
            rdata = read_data;
        end
    end

    // The access is served from these copies, so bus changes after acceptance are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (state == ST_IDLE && req) begin
            wait_cnt  <= WAIT_LOAD;
            req_we    <= we;
            req_addr  <= addr;
            req_wdata <= wdata;
        end else if (state == ST_WAIT) begin
            wait_cnt  <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in0_meta <= '0;
            in0_sync <= '0;
            in1_meta <= '0;
            in1_sync <= '0;
        end else begin
            in0_meta <= in0;
            in0_sync <= in0_meta;
            in1_meta <= in1;
            in1_sync <= in1_meta;
        end
    end

    assign wr_en     = (state == ST_ACK) && req_we;
    assign clr_count = wr_en && (req_addr == ADDR_TIMER);
    assign clr_flag  = wr_en && (req_addr == ADDR_STATUS) && req_wdata[STATUS_FLAG_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            out0 <= '0;
            out1 <= '0;
            tcmp <= '0;
            ie   <= 1'b0;
        end else if (wr_en) begin
            case (req_addr)
                ADDR_OUT0:   out0 <= req_wdata;
                ADDR_OUT1:   out1 <= req_wdata;
                ADDR_TCMP:   tcmp <= req_wdata;
                ADDR_STATUS: ie   <= req_wdata[STATUS_IE_BIT];
                default: ;
            endcase
        end
    end

    always_comb begin
        read_data = '0;
        case (req_addr)
            ADDR_OUT0:   read_data = out0;
            ADDR_OUT1:   read_data = out1;
            ADDR_IN0:    read_data = in0_sync;
            ADDR_IN1:    read_data = in1_sync;
            ADDR_TIMER:  read_data = count;
            ADDR_TCMP:   read_data = tcmp;
            ADDR_STATUS: begin
                read_data[STATUS_FLAG_BIT] = flag;
                read_data[STATUS_IE_BIT]   = ie;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= flag & ie;
        end
    end

    io_timer #(
        .WIDTH (WIDTH),
        .PRESC (PRESC)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_count (clr_count),
        .tcmp      (tcmp),
        .clr_flag  (clr_flag),
        .count     (count),
        .flag      (flag)
    );

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed handshake, timer and reset
// scenarios followed by randomized register traffic against a behavioural model.
module tb_io_responder;

    localparam int WIDTH       = 8;
    localparam int WAIT_CYCLES = 2;
    localparam int PRESC       = 4;

    logic             clk;
    logic             reset;
    logic             req;
    logic             we;
    logic [3:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ack;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             irq;

    io_responder #(
        .WIDTH       (WIDTH),
        .WAIT_CYCLES (WAIT_CYCLES),
        .PRESC       (PRESC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .in0   (in0),
        .in1   (in1),
        .out0  (out0),
        .out1  (out1),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    // Results of the most recent bus access
    int               r_lat;
    int               r_extra;
    int               r_stray;
    int               r_commit;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] r_out0_pre;
    logic [WIDTH-1:0] r_out0_post;
    logic [WIDTH-1:0] r_out1_post;
    logic             r_irq_post;
    logic             r_irq_post2;

    // Behavioural model state; timer edges are counted relative to the last TIMER clear
    logic [7:0] m_out0 = 8'h00;
    logic [7:0] m_out1 = 8'h00;
    logic [7:0] m_in0  = 8'h00;
    logic [7:0] m_in1  = 8'h00;
    logic [7:0] m_tcmp = 8'h00;
    logic       m_ie   = 1'b0;
    int         clr_edge = 0;
    int         wc_list[$];

    function automatic logic [7:0] count_at(input int e);
        int t;
        t = e / PRESC;
        if (m_tcmp == 8'h00) return 8'(t % 256);
        return 8'(t % (int'(m_tcmp) + 1));
    endfunction

    function automatic logic flag_at(input int e);
        int period;
        int last_set;
        int last_wc;
        period = (int'(m_tcmp) + 1) * PRESC;
        if (m_tcmp == 8'h00 || e < period) return 1'b0;
        last_set = (e / period) * period;
        last_wc = -1;
        foreach (wc_list[i]) begin
            if (wc_list[i] <= e && wc_list[i] > last_wc) last_wc = wc_list[i];
        end
        return last_set >= last_wc;
    endfunction

    function automatic logic irq_at(input int edge_idx);
        return m_ie && flag_at(edge_idx - 1 - clr_edge);
    endfunction

    function automatic logic [7:0] read_model(input logic [3:0] a, input int edge_idx);
        int e;
        e = edge_idx - clr_edge;
        case (a)
            4'd0:    return m_out0;
            4'd1:    return m_out1;
            4'd2:    return m_in0;
            4'd3:    return m_in1;
            4'd4:    return count_at(e);
            4'd5:    return m_tcmp;
            4'd6:    return {6'b0, m_ie, flag_at(e)};
            default: return 8'h00;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge with req low.
    task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [WIDTH-1:0] d, input int hold_extra);
        r_lat = -1; r_extra = 0; r_stray = 0; r_commit = -1;
        r_rdata = '0; r_out0_pre = '0; r_out0_post = '0; r_out1_post = '0;
        r_irq_post = 1'b0; r_irq_post2 = 1'b0;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int k = 0; k <= 30 && r_lat < 0; k++) begin
            @(negedge clk);
            if (ack) begin
                r_lat = k; r_rdata = rdata; r_out0_pre = out0; r_commit = cyc + 1;
            end else if (rdata !== '0) begin
                r_stray++;
            end
            if (k == 1) begin
                we = ~w; addr = ~a; wdata = ~d;
            end
        end
        if (r_lat >= 0) begin
            @(negedge clk);
            r_out0_post = out0; r_out1_post = out1; r_irq_post = irq;
            if (ack) r_extra++; else if (rdata !== '0) r_stray++;
            for (int i = 0; i < hold_extra; i++) begin
                @(negedge clk);
                if (ack) r_extra++; else if (rdata !== '0) r_stray++;
            end
        end
        req = 1'b0;
        @(negedge clk);
        r_irq_post2 = irq;
        if (ack) r_extra++; else if (rdata !== '0) r_stray++;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         first_irq;
        int         period;
        int         acks;
        logic       w;
        logic [3:0] a;
        logic [7:0] d;

        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; in0 = '0; in1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ack",   32'(ack),   32'(0));
        checkOutput("reset_rdata", 32'(rdata), 32'(0));
        checkOutput("reset_out0",  32'(out0),  32'(0));
        checkOutput("reset_out1",  32'(out1),  32'(0));
        checkOutput("reset_irq",   32'(irq),   32'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Write OUT0 while req stays high for several extra cycles
        applyStimulus(1'b1, 4'd0, 8'hA5, 4);
        m_out0 = 8'hA5;
        checkOutput("wr_out0_latency",   32'(r_lat),       32'(WAIT_CYCLES + 1));
        checkOutput("wr_out0_old_in_ack", 32'(r_out0_pre), 32'(0));
        checkOutput("wr_out0_new_after", 32'(r_out0_post), 32'(m_out0));
        checkOutput("wr_out0_single_ack", 32'(r_extra),    32'(0));

        // Synchronised input read
        in1 = 8'h3C; m_in1 = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'd3, 8'h00, 1);
        checkOutput("rd_in1_latency", 32'(r_lat),   32'(WAIT_CYCLES + 1));
        checkOutput("rd_in1_data",    32'(r_rdata), 32'(m_in1));
        checkOutput("rd_in1_rdata_idle_zero", 32'(r_stray), 32'(0));

        // Unmapped address
        applyStimulus(1'b0, 4'd9, 8'h00, 0);
        checkOutput("rd_unmapped", 32'(r_rdata), 32'(0));
        applyStimulus(1'b1, 4'd9, 8'hFF, 0);
        checkOutput("wr_unmapped_latency", 32'(r_lat),       32'(WAIT_CYCLES + 1));
        checkOutput("wr_unmapped_out0",    32'(r_out0_post), 32'(m_out0));
        checkOutput("wr_unmapped_out1",    32'(r_out1_post), 32'(m_out1));
        applyStimulus(1'b0, 4'd5, 8'h00, 0);
        checkOutput("wr_unmapped_tcmp", 32'(r_rdata), 32'(0));
        applyStimulus(1'b0, 4'd6, 8'h00, 0);
        checkOutput("wr_unmapped_status", 32'(r_rdata), 32'(0));

        // Timer: compare 3, restart count, enable interrupt and clear any stale flag
        applyStimulus(1'b1, 4'd5, 8'h03, 0);
        m_tcmp = 8'h03;
        applyStimulus(1'b1, 4'd4, 8'h5A, 0);
        clr_edge = r_commit;
        applyStimulus(1'b1, 4'd6, 8'h03, 0);
        m_ie = 1'b1;
        wc_list.push_back(r_commit - clr_edge);
        period = (int'(m_tcmp) + 1) * PRESC;

        first_irq = -1;
        for (int i = 0; i < 3 * period && first_irq < 0; i++) begin
            @(negedge clk);
            if (irq) first_irq = cyc - clr_edge;
        end
        checkOutput("irq_first_rise", 32'(first_irq), 32'(period + 1));
        @(posedge clk); #1;

        applyStimulus(1'b0, 4'd4, 8'h00, 0);
        checkOutput("timer_count", 32'(r_rdata), 32'(read_model(4'd4, r_commit - 1)));
        applyStimulus(1'b0, 4'd6, 8'h00, 0);
        checkOutput("status_flag_set", 32'(r_rdata), 32'(read_model(4'd6, r_commit - 1)));

        // Clear the flag away from a match edge; irq must follow one cycle later
        if (((cyc - clr_edge + WAIT_CYCLES + 2) % period) == 0) begin
            @(posedge clk); #1;
        end
        applyStimulus(1'b1, 4'd6, 8'h03, 0);
        wc_list.push_back(r_commit - clr_edge);
        checkOutput("w1c_irq_still_high", 32'(r_irq_post),  32'(irq_at(r_commit)));
        checkOutput("w1c_irq_dropped",    32'(r_irq_post2), 32'(irq_at(r_commit + 1)));
        applyStimulus(1'b0, 4'd6, 8'h00, 0);
        checkOutput("status_after_w1c", 32'(r_rdata), 32'(read_model(4'd6, r_commit - 1)));

        // Clear landing exactly on a match edge: the set must win
        for (int i = 0; i <= period && ((cyc - clr_edge + WAIT_CYCLES + 2) % period) != 0; i++) begin
            @(posedge clk); #1;
        end
        applyStimulus(1'b1, 4'd6, 8'h03, 0);
        wc_list.push_back(r_commit - clr_edge);
        applyStimulus(1'b0, 4'd6, 8'h00, 0);
        checkOutput("coincident_status", 32'(r_rdata),    32'(read_model(4'd6, r_commit - 1)));
        checkOutput("coincident_flag",   32'(r_rdata[0]), 32'(1));

        // Randomized traffic; timer registers are only read here
        for (int n = 0; n < 24; n++) begin
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            m_in0 = 8'($urandom); m_in1 = 8'($urandom);
            in0 = m_in0; in1 = m_in1;
            if (w) begin
                a = 4'($urandom_range(0, 12));
                if (a >= 4'd4) a = a + 4'd3;
            end else begin
                a = 4'($urandom_range(0, 15));
            end
            applyStimulus(w, a, d, int'($urandom_range(0, 2)));
            checkOutput("rand_latency", 32'(r_lat), 32'(WAIT_CYCLES + 1));
            if (w) begin
                if (a == 4'd0) m_out0 = d;
                if (a == 4'd1) m_out1 = d;
                checkOutput("rand_out0", 32'(r_out0_post), 32'(m_out0));
                checkOutput("rand_out1", 32'(r_out1_post), 32'(m_out1));
            end else begin
                checkOutput("rand_read", 32'(r_rdata), 32'(read_model(a, r_commit - 1)));
                checkOutput("rand_rdata_idle_zero", 32'(r_stray), 32'(0));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of a write to OUT1 aborts it
        applyStimulus(1'b1, 4'd1, 8'h5C, 0);
        m_out1 = 8'h5C;
        checkOutput("pre_reset_out1", 32'(r_out1_post), 32'(m_out1));
        req = 1'b1; we = 1'b1; addr = 4'd1; wdata = 8'h77;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        m_out0 = 8'h00; m_out1 = 8'h00; m_tcmp = 8'h00; m_ie = 1'b0;
        checkOutput("abort_no_ack", 32'(acks), 32'(0));
        checkOutput("abort_out1",   32'(out1), 32'(m_out1));
        checkOutput("abort_out0",   32'(out0), 32'(m_out0));
        checkOutput("abort_irq",    32'(irq),  32'(0));
        @(posedge clk); #1;
        applyStimulus(1'b0, 4'd1, 8'h00, 0);
        checkOutput("abort_idle_latency", 32'(r_lat),   32'(WAIT_CYCLES + 1));
        checkOutput("abort_read_out1",    32'(r_rdata), 32'(m_out1));
        applyStimulus(1'b0, 4'd5, 8'h00, 0);
        checkOutput("abort_tcmp", 32'(r_rdata), 32'(0));
        applyStimulus(1'b0, 4'd6, 8'h00, 0);
        checkOutput("abort_status", 32'(r_rdata), 32'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
